// File: rtl/char_rate_fifo.sv
// -----------------------------------------------------------------------------
// char_rate_fifo
//
// Buffers ASCII characters coming from the mode/command decoder in a circular
// FIFO and releases them toward a character sink (UART TX / display writer)
// at a selectable rate, one character per rate tick, using a valid/ready
// handshake.
//
// Ports
//   clk            in   1         system clock, single domain
//   reset          in   1         asynchronous, active-low reset
//   iData          in   8         character from the decoder
//   iWRen          in   1         write request (level); pushes on its rising edge
//   iSTART         in   1         1 = release enabled, 0 = paused
//   irate_control  in   2         rate select: 00 -> DIV0, 01 -> DIV1, 1x -> DIV2
//   iReady         in   1         sink accepts oData this cycle
//   oData          out  8         released character, stable while oValid=1
//   oValid         out  1         oData valid, held until accepted
//   oEmpty         out  1         occupancy == 0
//   oFull          out  1         occupancy == DEPTH
//   oCount         out  ADDR_W+1  current occupancy
//   oOverflow      out  1         sticky: a push was dropped while full
//
// Build option
//   CHAR_FILTER_EN : when defined, pushes of non-printable bytes (outside
//                    8'h20..8'h7E) are silently discarded. When undefined,
//                    every byte value is stored.
// -----------------------------------------------------------------------------
module char_rate_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int DIV0   = 50_000_000,
   parameter int DIV1   = 10_000_000,
   parameter int DIV2   = 5_000_000,
   parameter int CNT_W  = 26
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        iData,
   input  logic              iWRen,
   input  logic              iSTART,
   input  logic [1:0]        irate_control,
   input  logic              iReady,
   output logic [7:0]        oData,
   output logic              oValid,
   output logic              oEmpty,
   output logic              oFull,
   output logic [ADDR_W:0]   oCount,
   output logic              oOverflow
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0]  DIV0_M1  = CNT_W'(DIV0 - 1);
   localparam logic [CNT_W-1:0]  DIV1_M1  = CNT_W'(DIV1 - 1);
   localparam logic [CNT_W-1:0]  DIV2_M1  = CNT_W'(DIV2 - 1);
   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t              state_q,     state_d;
   logic [ADDR_W-1:0]   wr_ptr_q,    wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q,    rd_ptr_d;
   logic [ADDR_W:0]     count_q,     count_d;
   logic [CNT_W-1:0]    cnt_q,       cnt_d;
   logic [1:0]          rate_q,      rate_d;
   logic                wren_prev_q, wren_prev_d;
   logic [7:0]          data_q,      data_d;
   logic                valid_q,     valid_d;
   logic                ovf_q,       ovf_d;

   logic [7:0]          mem [DEPTH];

   // Control strobes
   logic                tick;
   logic [CNT_W-1:0]    div_m1;
   logic                push_req;
   logic                push_ok;
   logic                full;
   logic                pop;
   logic                do_push;

   // ---------------------------------------------------------------------------
   // Rate counter / tick generator
   // ---------------------------------------------------------------------------
   // NOTE: every signal assigned in an always_comb gets a default at the top of
   // the block, so no path can leave it unassigned and infer a latch.
   always_comb begin
      cnt_d  = cnt_q;
      rate_d = irate_control;
      tick   = 1'b0;
      div_m1 = DIV2_M1;

      case (irate_control)
         2'b00:   div_m1 = DIV0_M1;
         2'b01:   div_m1 = DIV1_M1;
         default: div_m1 = DIV2_M1;
      endcase

      if (!iSTART) begin
         cnt_d = '0;
      end else if (irate_control != rate_q) begin
         // Rate switch restarts the period; the switch cycle never ticks.
         cnt_d = '0;
      end else if (state_q == HOLD && !iReady) begin
         // Sink is stalling: freeze the period so it is stretched by the stall
         // and the next character follows a full period after acceptance.
         cnt_d = cnt_q;
      end else if (cnt_q == div_m1) begin
         tick  = 1'b1;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Push / pop qualification and FIFO bookkeeping
   // ---------------------------------------------------------------------------
   always_comb begin
      wren_prev_d = iWRen;
      push_req    = iWRen & ~wren_prev_q;

`ifdef CHAR_FILTER_EN
      push_ok     = push_req & (iData >= 8'h20) & (iData <= 8'h7E);
`else
      push_ok     = push_req;
`endif

      full        = (count_q == FULL_CNT);
      pop         = (state_q == IDLE) & tick & (count_q != '0);
      // A pop in the same cycle frees a slot, so a push into a full FIFO is
      // still accepted then.
      do_push     = push_ok & (~full | pop);
      ovf_d       = ovf_q | (push_ok & full & ~pop);

      wr_ptr_d    = do_push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
      rd_ptr_d    = pop     ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

      count_d     = count_q;
      case ({do_push, pop})
         2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
         2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      valid_d = valid_q;

      case (state_q)
         IDLE: begin
            if (pop) begin
               data_d  = mem[rd_ptr_q];
               valid_d = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            // Ticks are ignored here; iSTART dropping does not retract oValid.
            if (iReady) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential blocks use non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop regardless of block order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cnt_q       <= '0;
         rate_q      <= 2'b00;
         wren_prev_q <= 1'b0;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cnt_q       <= cnt_d;
         rate_q      <= rate_d;
         wren_prev_q <= wren_prev_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         ovf_q       <= ovf_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers and count
   // alone decide which entries hold live data, and leaving it unreset lets it
   // map onto plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= iData;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign oData     = data_q;
   assign oValid    = valid_q;
   assign oCount    = count_q;
   assign oEmpty    = (count_q == '0);
   assign oFull     = (count_q == FULL_CNT);
   assign oOverflow = ovf_q;

endmodule

// File: tb/tb_char_rate_fifo.sv
// -----------------------------------------------------------------------------
// tb_char_rate_fifo
//
// Directed self-checking bench for char_rate_fifo with DIV0=4, DIV1=8,
// DIV2=16, DEPTH=16. Inputs are driven 1 ns after the rising edge and outputs
// are sampled at the same point, so every value seen reflects the last edge.
// Build with CHAR_FILTER_EN defined to exercise the printable-only filter.
// -----------------------------------------------------------------------------
module tb_char_rate_fifo;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [7:0]        iData;
   logic              iWRen;
   logic              iSTART;
   logic [1:0]        irate_control;
   logic              iReady;
   logic [7:0]        oData;
   logic              oValid;
   logic              oEmpty;
   logic              oFull;
   logic [ADDR_W:0]   oCount;
   logic              oOverflow;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   char_rate_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DIV0   (4),
      .DIV1   (8),
      .DIV2   (16),
      .CNT_W  (26)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .iData         (iData),
      .iWRen         (iWRen),
      .iSTART        (iSTART),
      .irate_control (irate_control),
      .iReady        (iReady),
      .oData         (oData),
      .oValid        (oValid),
      .oEmpty        (oEmpty),
      .oFull         (oFull),
      .oCount        (oCount),
      .oOverflow     (oOverflow)
   );

   always #5 clk = ~clk;

   // Edge counter: after the k-th rising edge (sampled 1 ns later) cyc == k.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_char(input logic [7:0] c);
      iData = c;
      iWRen = 1'b1;
      step(1);
      iWRen = 1'b0;
      step(1);
   endtask

   task automatic do_reset();
      iWRen         = 1'b0;
      iSTART        = 1'b0;
      irate_control = 2'b00;
      iReady        = 1'b0;
      iData         = 8'h00;
      reset         = 1'b0;
      #2;
      reset         = 1'b1;
      step(1);
   endtask

   // Waits (bounded) for oValid; returns the edge index at which it was seen.
   task automatic wait_valid(input string tag, input int limit, output int at_cyc);
      int n = 0;
      while (oValid !== 1'b1 && n < limit) begin
         step(1);
         n++;
      end
      check(tag, oValid, 1);
      at_cyc = cyc;
   endtask

   initial begin
      #100_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int    a, b, c, d, raise_cyc, sw_cyc;
      bit    stable;

      // ---------------- Reset values ----------------
      reset         = 1'b0;
      iWRen         = 1'b0;
      iSTART        = 1'b0;
      irate_control = 2'b00;
      iReady        = 1'b0;
      iData         = 8'h00;
      step(2);
      check("rst_oData",     oData,     8'h00);
      check("rst_oValid",    oValid,    0);
      check("rst_oEmpty",    oEmpty,    1);
      check("rst_oFull",     oFull,     0);
      check("rst_oCount",    oCount,    0);
      check("rst_oOverflow", oOverflow, 0);
      reset = 1'b1;
      step(1);

      // ---------------- 1: level iWRen pushes once ----------------
      iData = 8'h41;
      iWRen = 1'b1;
      step(5);
      iWRen = 1'b0;
      step(1);
      check("t1_count_one_push", oCount, 1);
      check("t1_not_empty",      oEmpty, 0);
      check("t1_no_release",     oValid, 0);

      // ---------------- 2: "HI" released 4 cycles apart ----------------
      do_reset();
      push_char(8'h48);
      push_char(8'h49);
      check("t2_count", oCount, 2);
      iReady = 1'b1;
      iSTART = 1'b1;
      wait_valid("t2_first_valid", 20, a);
      check("t2_first_data", oData, 8'h48);
      step(1);
      check("t2_accepted", oValid, 0);
      wait_valid("t2_second_valid", 20, b);
      check("t2_second_data", oData, 8'h49);
      check("t2_gap", b - a, 4);
      step(1);
      check("t2_drop", oValid, 0);
      check("t2_empty", oEmpty, 1);

      // ---------------- 3: overflow, ordering, push+pop when full, reset in HOLD
      do_reset();
      for (int i = 0; i < 17; i++) push_char(8'h61 + 8'(i));
      check("t3_full",     oFull,     1);
      check("t3_count",    oCount,    16);
      check("t3_overflow", oOverflow, 1);
      iReady = 1'b1;
      iSTART = 1'b1;
      wait_valid("t3_valid", 20, a);
      check("t3_first_char", oData,  8'h61);
      check("t3_count_pop",  oCount, 15);
      check("t3_not_full",   oFull,  0);
      push_char(8'h7A);                      // pushed at edge a+1 -> full again
      check("t3_refull", oFull, 1);
      step(1);                               // now just after edge a+3
      iData = 8'h7B;
      iWRen = 1'b1;
      step(1);                               // edge a+4: tick pop + push while full
      iWRen = 1'b0;
      check("t3_pp_valid", oValid, 1);
      check("t3_pp_data",  oData,  8'h62);
      check("t3_pp_count", oCount, 16);
      // Reset while in HOLD: oValid must drop without a clock edge.
      reset = 1'b0;
      #1;
      check("t3_rst_hold_valid", oValid, 0);
      check("t3_rst_hold_count", oCount, 0);
      check("t3_rst_hold_ovf",   oOverflow, 0);
      reset = 1'b1;

      // ---------------- 4: sink stall ----------------
      do_reset();
      push_char(8'h41);
      push_char(8'h42);
      push_char(8'h43);
      iReady = 1'b0;
      iSTART = 1'b1;
      wait_valid("t4_valid", 20, a);
      check("t4_first_data", oData, 8'h41);
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (oValid !== 1'b1 || oData !== 8'h41) stable = 1'b0;
      end
      check("t4_stable",   stable, 1);
      check("t4_no_extra", oCount, 2);
      iReady    = 1'b1;
      raise_cyc = cyc;
      step(1);
      check("t4_accepted", oValid, 0);
      wait_valid("t4_next_valid", 20, b);
      check("t4_next_data", oData, 8'h42);
      check("t4_next_gap", b - raise_cyc, 4);

      // ---------------- 5: rate switching ----------------
      do_reset();
      push_char(8'h31);
      push_char(8'h32);
      push_char(8'h33);
      push_char(8'h34);
      iReady = 1'b1;
      iSTART = 1'b1;
      wait_valid("t5_valid0", 20, a);
      check("t5_data0", oData, 8'h31);
      step(1);
      // Switch 00 -> 10 mid-period. The counter restarts at 0 on the edge
      // after the switch cycle; the tick comes 16 cycles after that and the
      // character is registered one edge later: 17 edges after sw_cyc.
      irate_control = 2'b10;
      sw_cyc        = cyc;
      wait_valid("t5_valid1", 40, b);
      check("t5_data1", oData, 8'h32);
      check("t5_gap_10", b - sw_cyc, 17);
      irate_control = 2'b11;                 // 10 -> 11 is also a change
      step(1);
      check("t5_accepted", oValid, 0);
      wait_valid("t5_valid2", 40, c);
      check("t5_data2", oData, 8'h33);
      check("t5_gap_11", c - b, 17);
      irate_control = 2'b01;                 // 11 -> 01: period 8
      step(1);
      wait_valid("t5_valid3", 40, d);
      check("t5_data3", oData, 8'h34);
      check("t5_gap_01", d - c, 9);

      // ---------------- 6: character filter ----------------
      do_reset();
      push_char(8'h0D);
      push_char(8'h41);
      push_char(8'h7F);
`ifdef CHAR_FILTER_EN
      check("t6_count",    oCount,    1);
      check("t6_overflow", oOverflow, 0);
      iReady = 1'b1;
      iSTART = 1'b1;
      wait_valid("t6_valid", 20, a);
      check("t6_data", oData, 8'h41);
      step(10);
      check("t6_no_more", oValid, 0);
      check("t6_empty",   oEmpty, 1);
`else
      check("t6_count",    oCount,    3);
      check("t6_overflow", oOverflow, 0);
      iReady = 1'b1;
      iSTART = 1'b1;
      wait_valid("t6_valid", 20, a);
      check("t6_data", oData, 8'h0D);
      step(1);
      wait_valid("t6_valid2", 20, b);
      check("t6_data2", oData, 8'h41);
      step(1);
      wait_valid("t6_valid3", 20, c);
      check("t6_data3", oData, 8'h7F);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
